// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, request-to-send, shift, ACK, idle wait)
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2440,
    parameter int TIMEOUT_CYCLES = 366000
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int MAXC = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE} state_t;

    state_t          r_state, w_next;
    logic            r_clk_s1, r_clk_s2, r_clk_d, r_dat_s1, r_dat_s2;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_bit;
    logic [9:0]      r_frame;
    logic            r_dout, r_ack_ok, r_done, r_err;
    logic            w_done, w_err, w_fall, w_run, w_timeout;
    logic [3:0]      w_bit_nxt;

    assign w_fall    = r_clk_d & ~r_clk_s2;
    assign w_run     = (r_state == S_REQ) || (r_state == S_SHIFT) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
    assign w_timeout = w_run && (r_cnt == TO_LAST);
    assign w_bit_nxt = r_bit + 4'd1;

    // Two-flop synchronizers on the open-collector lines plus a delayed clock for edge detection
    always_ff @(posedge pclk) begin
        if (reset) begin
            {r_clk_s1, r_clk_s2, r_clk_d, r_dat_s1, r_dat_s2} <= 5'b11111;
        end else begin
            r_clk_s1 <= ps2_clk_in;
            r_clk_s2 <= r_clk_s1;
            r_clk_d  <= r_clk_s2;
            r_dat_s1 <= ps2_data_in;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // State register
    always_ff @(posedge pclk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state and completion pulses; the timeout overrides any bit position
    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            S_IDLE:      if (tx_valid) w_next = S_INHIBIT;
            S_INHIBIT:   if (r_cnt == INH_LAST) w_next = S_REQ;
            S_REQ:       if (w_fall) w_next = S_SHIFT;
            S_SHIFT:     if (w_fall && r_bit == 4'd8) w_next = S_ACK;
            S_ACK:       if (w_fall) w_next = S_WAIT_IDLE;
            S_WAIT_IDLE: if (r_clk_s2 && r_dat_s2) begin
                w_next = S_IDLE;
                w_done = r_ack_ok;
                w_err  = ~r_ack_ok;
            end
            default:     w_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_next = S_IDLE;
            w_done = 1'b0;
            w_err  = 1'b1;
        end
    end

    // Inhibit/timeout counter, frame capture, bit shifting, ACK sample and result pulses
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_bit    <= '0;
            r_frame  <= '0;
            r_dout   <= 1'b1;
            r_ack_ok <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_cnt    <= (r_state == S_IDLE || w_next == S_IDLE || (r_state == S_INHIBIT && w_next == S_REQ)) ? '0 : r_cnt + 1'b1;
            r_bit    <= (r_state == S_SHIFT) ? (w_fall ? w_bit_nxt : r_bit) : '0;
            r_dout   <= (r_state == S_IDLE) ? 1'b1 :
                        (r_state == S_REQ && w_fall) ? r_frame[0] :
                        (r_state == S_SHIFT && w_fall) ? r_frame[w_bit_nxt] : r_dout;
            r_ack_ok <= (r_state == S_ACK && w_fall) ? ~r_dat_s2 : r_ack_ok;
            r_done   <= w_done;
            r_err    <= w_err;
            if (r_state == S_IDLE && tx_valid) r_frame <= {1'b1, ~^tx_data, tx_data};
        end
    end

    assign tx_ready    = (r_state == S_IDLE);
    assign tx_done     = r_done;
    assign tx_error    = r_err;
    assign ps2_clk_oe  = (r_state == S_INHIBIT);
    assign ps2_data_oe = (r_state == S_INHIBIT && r_cnt == INH_LAST) || (r_state == S_REQ) || (r_state == S_SHIFT && !r_dout);
endmodule
